// File: rtl/reg_file_mp_pkg.sv
// Shared defaults and helpers for the multi-ported register file.
package reg_file_mp_pkg;

  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;
  localparam int REG_ZERO = 0;  // hard-wired zero register index

  // Address width for n registers; never narrower than one bit.
  function automatic int clog2_aw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Read/write/scoreboard bus of the register file.
interface reg_file_mp_if
  import reg_file_mp_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  parameter int AW   = clog2_aw(NREG)
) ();

  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_valid;
  logic                we;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                busy_set;
  logic [AW-1:0]       busy_addr;
  logic [NREG-1:0]     busy_vec;

  modport master (
    output rd_en, rd_addr, we, wr_addr, wr_data, busy_set, busy_addr,
    input  rd_data, rd_valid, busy_vec
  );

  modport slave (
    input  rd_en, rd_addr, we, wr_addr, wr_data, busy_set, busy_addr,
    output rd_data, rd_valid, busy_vec
  );

endinterface

// File: rtl/reg_file_rdport.sv
// One read port: address mux, write forwarding, output register and valid.
module reg_file_rdport
  import reg_file_mp_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int BYPASS = 1,
  parameter int AW     = clog2_aw(NREG)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_en,
  input  logic [AW-1:0]             i_addr,
  input  logic [NREG-1:0][XLEN-1:0] i_regs,
  input  logic [NREG-1:0]           i_busy,
  input  logic                      i_we,
  input  logic [AW-1:0]             i_wr_addr,
  input  logic [XLEN-1:0]           i_wr_data,
  output logic [XLEN-1:0]           o_data,
  output logic                      o_valid
);

  logic            w_inrange;
  logic            w_wr_hit;
  logic            w_busy;
  logic [XLEN-1:0] w_data;
  logic [XLEN-1:0] r_data;
  logic            r_valid;

  // Select read value; a same-cycle write to this address both forwards its
  // data and (with forwarding) counts as having cleared the busy mark.
  always_comb begin
    w_inrange = 32'(i_addr) < NREG;
    w_wr_hit  = i_we && (i_wr_addr == i_addr) && (i_addr != AW'(REG_ZERO));
    w_busy    = w_inrange && i_busy[i_addr];
    w_data    = '0;
    if (BYPASS != 0 && w_wr_hit) w_busy = 1'b0;
    if (w_inrange) w_data = (BYPASS != 0 && w_wr_hit) ? i_wr_data : i_regs[i_addr];
  end

  // Output register: data holds when idle, valid is a one-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_en && w_inrange && !w_busy;
      if (i_en) r_data <= w_data;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with zero register and busy scoreboard.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = clog2_aw(NREG)
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_mp_if.slave bus
);

  logic [NREG-1:0][XLEN-1:0] r_regs;
  logic [NREG-1:0]           r_busy;
  logic                      w_wr_ok;
  logic [NRD-1:0][XLEN-1:0]  w_rd_data;
  logic [NRD-1:0]            w_rd_valid;

  assign w_wr_ok = bus.we && (bus.wr_addr != AW'(REG_ZERO)) && (32'(bus.wr_addr) < NREG);

  // Storage; entry 0 is never written so it stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_regs <= '0;
    else if (w_wr_ok) r_regs[bus.wr_addr] <= bus.wr_data;
  end

  // Scoreboard: a busy mark set in the same cycle as a write-clear survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (bus.busy_set && bus.busy_addr == AW'(r)) r_busy[r] <= 1'b1;
        else if (bus.we && bus.wr_addr == AW'(r))    r_busy[r] <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    reg_file_rdport #(.XLEN(XLEN), .NREG(NREG), .BYPASS(BYPASS), .AW(AW)) u_rdport (
      .clk       (clk),
      .rst       (rst),
      .i_en      (bus.rd_en[i]),
      .i_addr    (bus.rd_addr[i*AW +: AW]),
      .i_regs    (r_regs),
      .i_busy    (r_busy),
      .i_we      (bus.we),
      .i_wr_addr (bus.wr_addr),
      .i_wr_data (bus.wr_data),
      .o_data    (w_rd_data[i]),
      .o_valid   (w_rd_valid[i])
    );
  end

  assign bus.rd_data  = w_rd_data;
  assign bus.rd_valid = w_rd_valid;
  assign bus.busy_vec = r_busy;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench: forwarding (a), no forwarding (b), 24-entry file (c).
module tb_reg_file_mp;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  reg_file_mp_if #(.XLEN(64), .NREG(32), .NRD(4)) ifa ();
  reg_file_mp_if #(.XLEN(64), .NREG(32), .NRD(4)) ifb ();
  reg_file_mp_if #(.XLEN(64), .NREG(24), .NRD(4)) ifc ();

  reg_file_mp #(.XLEN(64), .NREG(32), .NRD(4), .BYPASS(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  reg_file_mp #(.XLEN(64), .NREG(32), .NRD(4), .BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  reg_file_mp #(.XLEN(64), .NREG(24), .NRD(4), .BYPASS(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  assign ifb.rd_en = ifa.rd_en;     assign ifc.rd_en = ifa.rd_en;
  assign ifb.rd_addr = ifa.rd_addr; assign ifc.rd_addr = ifa.rd_addr;
  assign ifb.we = ifa.we;           assign ifc.we = ifa.we;
  assign ifb.wr_addr = ifa.wr_addr; assign ifc.wr_addr = ifa.wr_addr;
  assign ifb.wr_data = ifa.wr_data; assign ifc.wr_data = ifa.wr_data;
  assign ifb.busy_set = ifa.busy_set;   assign ifc.busy_set = ifa.busy_set;
  assign ifb.busy_addr = ifa.busy_addr; assign ifc.busy_addr = ifa.busy_addr;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] en, input logic [4:0] a0, a1, a2, a3);
    ifa.rd_en   = en;
    ifa.rd_addr = {a3, a2, a1, a0};
  endtask

  task automatic wr(input logic w, input logic [4:0] a, input logic [63:0] d);
    ifa.we = w; ifa.wr_addr = a; ifa.wr_data = d;
  endtask

  task automatic bsy(input logic s, input logic [4:0] a);
    ifa.busy_set = s; ifa.busy_addr = a;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    clk = 1'b0; rst = 1'b1;
    rd(4'h0, 0, 0, 0, 0); wr(0, 0, 0); bsy(0, 0);
    #2;
    chk("rst_valid", ifa.rd_valid, 4'h0);
    chk("rst_busy", ifa.busy_vec, 32'h0);
    chk("rst_data", ifa.rd_data[63:0], 64'h0);

    // operations under reset must be ignored
    wr(1, 5, 64'h77); bsy(1, 6); rd(4'hF, 5, 5, 5, 5);
    tick();
    chk("rst_ign_valid", ifa.rd_valid, 4'h0);
    chk("rst_ign_busy", ifa.busy_vec, 32'h0);
    rst = 1'b0;
    wr(0, 0, 0); bsy(0, 0);

    // read x5 after reset
    rd(4'hF, 5, 5, 5, 5);
    tick();
    chk("x5_init_p0", ifa.rd_data[0*64 +: 64], 64'h0);
    chk("x5_init_p1", ifa.rd_data[1*64 +: 64], 64'h0);
    chk("x5_init_vld", ifa.rd_valid, 4'hF);

    // write x5, no read this cycle
    rd(4'h0, 0, 0, 0, 0); wr(1, 5, 64'hDEAD_BEEF_0000_0001);
    tick();
    chk("idle_vld", ifa.rd_valid, 4'h0);
    chk("idle_hold", ifa.rd_data[0*64 +: 64], 64'h0);
    wr(0, 0, 0); rd(4'hF, 5, 5, 5, 5);
    tick();
    chk("x5_p0", ifa.rd_data[0*64 +: 64], 64'hDEAD_BEEF_0000_0001);
    chk("x5_p3", ifa.rd_data[3*64 +: 64], 64'hDEAD_BEEF_0000_0001);
    chk("x5_vld", ifa.rd_valid, 4'hF);

    // x0 write discarded
    rd(4'h0, 0, 0, 0, 0); wr(1, 0, 64'hFF);
    tick();
    wr(0, 0, 0); rd(4'hF, 0, 0, 0, 0);
    tick();
    chk("x0_data", ifa.rd_data[0*64 +: 64], 64'h0);
    chk("x0_vld", ifa.rd_valid, 4'hF);

    // same-cycle write/read x7
    wr(1, 7, 64'h1234); rd(4'hF, 7, 7, 7, 7);
    tick();
    chk("byp1_x7", ifa.rd_data[0*64 +: 64], 64'h1234);
    chk("byp0_x7", ifb.rd_data[0*64 +: 64], 64'h0);
    chk("byp0_vld", ifb.rd_valid, 4'hF);

    // scoreboard
    wr(0, 0, 0); rd(4'h0, 0, 0, 0, 0); bsy(1, 9);
    tick();
    bsy(0, 0);
    chk("busy9_set", ifa.busy_vec, 32'h0000_0200);
    rd(4'hF, 9, 9, 9, 9);
    tick();
    chk("busy9_vld_a", ifa.rd_valid, 4'h0);
    chk("busy9_vld_b", ifb.rd_valid, 4'h0);
    wr(1, 9, 64'h55);
    tick();
    chk("wclr_vld_a", ifa.rd_valid, 4'hF);
    chk("wclr_data_a", ifa.rd_data[2*64 +: 64], 64'h55);
    chk("wclr_vld_b", ifb.rd_valid, 4'h0);
    chk("wclr_data_b", ifb.rd_data[0*64 +: 64], 64'h0);
    chk("wclr_busy", ifa.busy_vec, 32'h0);
    rd(4'h0, 0, 0, 0, 0); wr(1, 9, 64'h66); bsy(1, 9);
    tick();
    chk("set_wins", ifa.busy_vec, 32'h0000_0200);
    wr(0, 0, 0); bsy(1, 0);
    tick();
    chk("busy_x0", ifa.busy_vec, 32'h0000_0200);

    // mixed addresses across ports
    bsy(0, 0); rd(4'hF, 5, 7, 9, 0);
    tick();
    chk("mix_p0", ifa.rd_data[0*64 +: 64], 64'hDEAD_BEEF_0000_0001);
    chk("mix_p1", ifa.rd_data[1*64 +: 64], 64'h1234);
    chk("mix_p2", ifa.rd_data[2*64 +: 64], 64'h66);
    chk("mix_p3", ifa.rd_data[3*64 +: 64], 64'h0);
    chk("mix_vld_a", ifa.rd_valid, 4'b1011);
    chk("mix_vld_b", ifb.rd_valid, 4'b1011);

    // out-of-range address on the 24-entry file
    rd(4'h0, 0, 0, 0, 0); wr(1, 30, 64'hAB);
    tick();
    wr(0, 0, 0); rd(4'hF, 30, 30, 30, 30); bsy(1, 30);
    tick();
    chk("oor_vld_c", ifc.rd_valid, 4'h0);
    chk("oor_data_c", ifc.rd_data[0*64 +: 64], 64'h0);
    chk("oor_busy_c", ifc.busy_vec, 24'h00_0200);
    chk("x30_vld_a", ifa.rd_valid, 4'hF);
    chk("x30_data_a", ifa.rd_data[1*64 +: 64], 64'hAB);
    bsy(0, 0); rd(4'h0, 0, 0, 0, 0);
    tick();
    chk("x30_busy_a", ifa.busy_vec, 32'h4000_0200);

    // asynchronous reset mid-operation
    bsy(1, 3);
    tick();
    bsy(0, 0); wr(1, 4, 64'hAA);
    tick();
    wr(0, 0, 0);
    chk("pre_rst_busy", ifa.busy_vec, 32'h4000_0208);
    rd(4'hF, 4, 4, 4, 4);
    tick();
    chk("pre_rst_x4", ifa.rd_data[0*64 +: 64], 64'hAA);
    #3 rst = 1'b1;
    #1;
    chk("arst_vld", ifa.rd_valid, 4'h0);
    chk("arst_busy", ifa.busy_vec, 32'h0);
    chk("arst_data", ifa.rd_data[0*64 +: 64], 64'h0);
    #1 rst = 1'b0;
    tick();
    chk("post_rst_x4", ifa.rd_data[0*64 +: 64], 64'h0);
    chk("post_rst_vld", ifa.rd_valid, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter XLEN, default 64, data width of each register.
REQ-002 SHALL have parameter NREG, default 32, register count; AW = clog2(NREG) derived.
REQ-003 SHALL have parameter NRD, default 2, number of independent read ports.
REQ-004 SHALL have parameter BYPASS, default 1; 1 = same-cycle write forwarded to reads, 0 = reads return pre-write value.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port rd_en  input  NRD  per-port read request.
REQ-008 SHALL have port rd_addr  input  NRD*AW  per-port read address, port i at [i*AW +: AW].
REQ-009 SHALL have port rd_data  output  NRD*XLEN  registered read data, port i at [i*XLEN +: XLEN].
REQ-010 SHALL have port rd_valid  output  NRD  per-port: rd_data holds a committed, non-busy value.
REQ-011 SHALL have port we  input  1  write enable.
REQ-012 SHALL have port wr_addr  input  AW  write address.
REQ-013 SHALL have port wr_data  input  XLEN  write data.
REQ-014 SHALL have port busy_set  input  1  mark busy_addr as pending write (issued long-latency producer).
REQ-015 SHALL have port busy_addr  input  AW  register to mark busy.
REQ-016 SHALL have port busy_vec  output  NREG  current scoreboard, bit r = register r pending.

Function
REQ-017 Register 0 SHALL read as zero at all times; writes to it are discarded; busy_set to it is ignored; busy_vec[0] is always 0.
REQ-018 Write SHALL commit on the rising edge where we=1 and wr_addr!=0; the new value is visible to reads requested on the following cycle.
REQ-019 Read latency SHALL be one cycle: rd_en[i]=1 in cycle N -> rd_data[i]/rd_valid[i] updated at the edge ending cycle N.
REQ-020 With rd_en[i]=0, rd_data[i] SHALL hold its last value and rd_valid[i] SHALL deassert.
REQ-021 BYPASS=1: read in cycle N with we=1, wr_addr=rd_addr[i]!=0 SHALL return wr_data; BYPASS=0: SHALL return the old stored value.
REQ-022 rd_valid[i] SHALL be 1 iff rd_en[i] was 1 and the address was not busy; for BYPASS=1 "busy" is evaluated after applying that cycle's write-clear.
REQ-023 A write (we=1) SHALL clear busy_vec[wr_addr] at the same edge.
REQ-024 busy_set SHALL set busy_vec[busy_addr] at the edge; simultaneous set and write-clear to same address SHALL leave it set (set wins).
REQ-025 Any number of read ports SHALL access the same address in the same cycle with identical results.
REQ-026 Out-of-range addresses (>= NREG when NREG not a power of 2) SHALL read zero, be not-valid, and writes/busy_set to them are discarded.

Reset
REQ-027 Assertion of rst SHALL immediately clear all registers, busy_vec, rd_data and rd_valid to zero, independent of clk.
REQ-028 During rst, we, busy_set and rd_en SHALL be ignored; the first operations accepted are on the first rising edge after deassertion.
REQ-029 Reset asserted mid-operation SHALL drop pending busy marks and any in-flight read result (no rd_valid after reset).

Structure
REQ-030 Shared package SHALL hold XLEN/NREG defaults, the AW derivation function and the reg-index constant for the zero register.
REQ-031 One sub-module reg_file_rdport SHALL implement a single read port (mux, bypass compare, output register, valid), instantiated NRD times via generate.
REQ-032 Storage and scoreboard SHALL live in reg_file_mp; no latches; no continuous assigns inside always blocks.

Verification
REQ-033 Reset then read x5 on ports 0,1 -> next cycle rd_data=0, rd_valid=11.
REQ-034 Write x5=0xDEAD_BEEF_0000_0001, read x5 next cycle -> rd_data=0xDEAD_BEEF_0000_0001, valid=1; write x0=0xFF, read x0 -> 0, valid=1.
REQ-035 Same-cycle write x7=0x1234 and read x7 -> BYPASS=1 returns 0x1234; BYPASS=0 returns prior value 0.
REQ-036 busy_set x9, read x9 -> rd_valid=0, busy_vec[9]=1; then write x9=0x55 with read -> BYPASS=1 valid=1 data 0x55; same-cycle busy_set+write x9 -> busy_vec[9] stays 1.
REQ-037 Set busy x3, write x4=0xAA, assert rst asynchronously mid-cycle -> busy_vec=0, rd_valid=0, x4 reads 0 after release.
REQ-038 NRD=4, all ports read x4 concurrently -> all four return identical data and valid.
